// File: rtl/noc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | noc_pkg : shared port indices, default flit layout, XY routing.   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package noc_pkg;

  localparam int NUM_PORTS     = 5;
  localparam int DEF_COORD_W   = 2;
  localparam int DEF_PAYLOAD_W = 32;
  localparam int DEF_FLIT_W    = 2 * DEF_COORD_W + DEF_PAYLOAD_W;

  typedef enum logic [2:0] {
    P_L = 3'd0,
    P_N = 3'd1,
    P_E = 3'd2,
    P_S = 3'd3,
    P_W = 3'd4
  } port_e;

  typedef struct packed {
    logic [DEF_COORD_W-1:0]   dst_x;
    logic [DEF_COORD_W-1:0]   dst_y;
    logic [DEF_PAYLOAD_W-1:0] payload;
  } flit_t;

  // Dimension-ordered: resolve X fully before Y.
  function automatic port_e route(input logic [7:0] x, input logic [7:0] y,
                                  input logic [7:0] dst_x, input logic [7:0] dst_y);
    if (dst_x > x)      return P_E;
    else if (dst_x < x) return P_W;
    else if (dst_y > y) return P_S;
    else if (dst_y < y) return P_N;
    else                return P_L;
  endfunction

endpackage
`default_nettype wire

// File: rtl/router_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | router_fifo : per-input flit buffer, MSB-compare full/empty.      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module router_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int c_AW = $clog2(DEPTH);

  logic [c_AW:0]      r_wp;
  logic [c_AW:0]      r_rp;
  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic               w_do_push;
  logic               w_do_pop;

  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  assign empty = (r_wp == r_rp);
  assign full  = (r_wp[c_AW] != r_rp[c_AW]) && (r_wp[c_AW-1:0] == r_rp[c_AW-1:0]);
  assign dout  = r_mem[r_rp[c_AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_do_push) r_wp <= r_wp + 1'b1;
      if (w_do_pop)  r_rp <= r_rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wp[c_AW-1:0]] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/mesh_router.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mesh_router : 5-port XY mesh router, per-input FIFO, RR outputs.  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module mesh_router
  import noc_pkg::*;
#(
  parameter int XCOORD     = 0,
  parameter int YCOORD     = 0,
  parameter int COORD_W    = 2,
  parameter int PAYLOAD_W  = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int HAS_N      = 1,
  parameter int HAS_E      = 1,
  parameter int HAS_S      = 1,
  parameter int HAS_W      = 1
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [NUM_PORTS-1:0]                           in_valid,
  output logic [NUM_PORTS-1:0]                           in_ready,
  input  logic [NUM_PORTS*(2*COORD_W+PAYLOAD_W)-1:0]     in_flit,
  output logic [NUM_PORTS-1:0]                           out_valid,
  input  logic [NUM_PORTS-1:0]                           out_ready,
  output logic [NUM_PORTS*(2*COORD_W+PAYLOAD_W)-1:0]     out_flit,
  output logic [15:0]                                    drop_count
);

  localparam int c_FLIT_W = 2 * COORD_W + PAYLOAD_W;
  localparam logic [NUM_PORTS-1:0] c_PRESENT =
    {(HAS_W != 0), (HAS_S != 0), (HAS_E != 0), (HAS_N != 0), 1'b1};

  logic                               r_alive;
  logic [15:0]                        r_drop;
  logic [16:0]                        w_drop_sum;
  logic [NUM_PORTS-1:0]               w_empty;
  logic [NUM_PORTS-1:0]               w_full;
  logic [NUM_PORTS-1:0]               w_mis;
  logic [NUM_PORTS-1:0]               w_pop;
  logic [NUM_PORTS*c_FLIT_W-1:0]      w_heads;
  logic [NUM_PORTS*NUM_PORTS-1:0]     w_dst;
  logic [NUM_PORTS*NUM_PORTS-1:0]     w_xfer;

  // in_ready stays low through reset and rises on the first edge after it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_alive <= 1'b0;
    else      r_alive <= 1'b1;
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_in
    logic [2:0] w_rt;

    if (c_PRESENT[p]) begin : g_fifo
      router_fifo #(
        .WIDTH (c_FLIT_W),
        .DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid[p] & in_ready[p]),
        .din   (in_flit[p*c_FLIT_W +: c_FLIT_W]),
        .pop   (w_pop[p]),
        .dout  (w_heads[p*c_FLIT_W +: c_FLIT_W]),
        .full  (w_full[p]),
        .empty (w_empty[p])
      );
      assign in_ready[p] = r_alive & ~w_full[p];
    end else begin : g_absent
      assign w_heads[p*c_FLIT_W +: c_FLIT_W] = '0;
      assign w_full[p]   = 1'b1;
      assign w_empty[p]  = 1'b1;
      assign in_ready[p] = 1'b0;
    end

    assign w_rt = route(8'(XCOORD), 8'(YCOORD),
                        8'(w_heads[p*c_FLIT_W + c_FLIT_W - 1 -: COORD_W]),
                        8'(w_heads[p*c_FLIT_W + c_FLIT_W - COORD_W - 1 -: COORD_W]));

    // Routes to a missing port, or back out the arrival port (local loopback excepted), are dropped.
    assign w_mis[p] = ~w_empty[p] &
                      (~c_PRESENT[w_rt] | ((w_rt == 3'(p)) && (p != 0)));
    assign w_dst[p*NUM_PORTS +: NUM_PORTS] =
      (~w_empty[p] & ~w_mis[p]) ? (NUM_PORTS'(1) << w_rt) : '0;
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    logic                 r_lock;
    logic [2:0]           r_lgrant;
    logic [2:0]           r_ptr;
    logic [NUM_PORTS-1:0] w_req;
    logic [3:0]           w_idx;
    logic [2:0]           w_rr;
    logic                 w_any;
    logic [2:0]           w_grant;
    logic                 w_valid;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_req
      assign w_req[p] = w_dst[p*NUM_PORTS + o];
    end

    always_comb begin
      w_any = 1'b0;
      w_rr  = r_ptr;
      w_idx = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        w_idx = 4'(r_ptr) + 4'(k);
        if (w_idx >= 4'(NUM_PORTS)) w_idx = w_idx - 4'(NUM_PORTS);
        if (!w_any && w_req[w_idx[2:0]]) begin
          w_any = 1'b1;
          w_rr  = w_idx[2:0];
        end
      end
    end

    assign w_grant      = r_lock ? r_lgrant : w_rr;
    assign w_valid      = c_PRESENT[o] & (r_lock | w_any);
    assign out_valid[o] = w_valid;
    assign out_flit[o*c_FLIT_W +: c_FLIT_W] =
      w_valid ? w_heads[w_grant*c_FLIT_W +: c_FLIT_W] : '0;
    assign w_xfer[o*NUM_PORTS +: NUM_PORTS] =
      (w_valid & out_ready[o]) ? (NUM_PORTS'(1) << w_grant) : '0;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_lock   <= 1'b0;
        r_lgrant <= '0;
        r_ptr    <= '0;
      end else begin
        r_lock   <= w_valid & ~out_ready[o];
        r_lgrant <= w_grant;
        if (w_valid & out_ready[o])
          r_ptr <= (w_grant == 3'(NUM_PORTS - 1)) ? 3'd0 : w_grant + 3'd1;
      end
    end
  end

  always_comb begin
    w_pop = w_mis;
    for (int o = 0; o < NUM_PORTS; o++)
      for (int p = 0; p < NUM_PORTS; p++)
        w_pop[p] = w_pop[p] | w_xfer[o*NUM_PORTS + p];
  end

  assign w_drop_sum = {1'b0, r_drop} + 17'($countones(w_mis));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_drop <= '0;
    else      r_drop <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
  end

  assign drop_count = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_mesh_router.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mesh_router : interior (1,1) and corner (0,0) router bench.    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_mesh_router;

  localparam int FW = 36;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    iv, ir, ov, ordy;
  logic [179:0]  ifl, ofl;
  logic [15:0]   drop;
  logic [4:0]    e_iv, e_ir, e_ov, e_ordy;
  logic [179:0]  e_ifl, e_ofl;
  logic [15:0]   e_drop;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mesh_router #(.XCOORD(1), .YCOORD(1), .COORD_W(2), .PAYLOAD_W(32), .FIFO_DEPTH(4),
                .HAS_N(1), .HAS_E(1), .HAS_S(1), .HAS_W(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .in_flit(ifl),
    .out_valid(ov), .out_ready(ordy), .out_flit(ofl), .drop_count(drop));

  mesh_router #(.XCOORD(0), .YCOORD(0), .COORD_W(2), .PAYLOAD_W(32), .FIFO_DEPTH(4),
                .HAS_N(0), .HAS_E(1), .HAS_S(1), .HAS_W(0)) u_edge (
    .clk(clk), .rst(rst), .in_valid(e_iv), .in_ready(e_ir), .in_flit(e_ifl),
    .out_valid(e_ov), .out_ready(e_ordy), .out_flit(e_ofl), .drop_count(e_drop));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; iv = '0; e_iv = '0; ordy = '0; e_ordy = 5'h1F;
    repeat (2) cyc();
    rst = 1'b1;
    cyc();
  endtask

  function automatic logic [35:0] mk(input int dx, input int dy, input logic [31:0] pl);
    return {2'(dx), 2'(dy), pl};
  endfunction

  // XY rule for the (1,1) router: 0=L 1=N 2=E 3=S 4=W
  function automatic int exp_port(input int dx, input int dy);
    if (dx > 1) return 2;
    if (dx < 1) return 4;
    if (dy > 1) return 3;
    if (dy < 1) return 1;
    return 0;
  endfunction

  logic [35:0] mq [25][$];
  logic [35:0] f, ef, flits [6];
  logic [31:0] r;
  int          k, got, bad, exp_drop, left, s, rp;
  int          dxs [5] = '{3, 0, 1, 1, 1};
  int          dys [5] = '{1, 1, 3, 0, 1};
  logic [4:0]  eps [5] = '{5'b00100, 5'b10000, 5'b01000, 5'b00010, 5'b00001};
  int          csrc [3] = '{0, 1, 4};

  initial begin
    ifl = '0; e_ifl = '0;
    // Reset behaviour
    rst = 1'b0; iv = 5'h1F; e_iv = 5'h1F; ordy = 5'h1F; e_ordy = 5'h1F;
    repeat (2) cyc();
    check_eq("rst_in_ready", 64'(ir), 64'(0));
    check_eq("rst_out_valid", 64'(ov), 64'(0));
    check_eq("rst_drop", 64'(drop), 64'(0));
    iv = '0; e_iv = '0;
    rst = 1'b1;
    #1 check_eq("ready_before_edge", 64'(ir), 64'(0));
    cyc();
    check_eq("ready_after_edge", 64'(ir), 64'h1F);
    check_eq("edge_ready_absent", 64'(e_ir), 64'b01101);

    // Routing from L, one hop each direction
    for (int i = 0; i < 5; i++) begin
      cyc();
      r = $urandom();
      f = mk(dxs[i], dys[i], r);
      iv = 5'b00001; ifl[0 +: FW] = f;
      #1 check_eq("no_bypass", 64'(ov), 64'(0));
      cyc();
      iv = '0;
      #1;
      check_eq("route_port", 64'(ov), 64'(eps[i]));
      for (int o = 0; o < 5; o++)
        if (eps[i][o]) check_eq("route_flit", 64'(ofl[o*FW +: FW]), 64'(f));
    end
    cyc();

    // Contention: L, N, W all to E
    do_reset();
    got = 0;
    for (int c = 0; c < 40 && got < 9; c++) begin
      cyc();
      iv = 5'b10011; ordy = 5'h1F;
      for (int p = 0; p < 5; p++) begin
        r = $urandom(); r[2:0] = 3'(p);
        ifl[p*FW +: FW] = mk(3, 1, r);
      end
      #1;
      if (ov[2]) begin
        check_eq("contention_src", 64'(ofl[2*FW +: 3]), 64'(csrc[got % 3]));
        got++;
      end
    end
    check_eq("contention_count", 64'(got), 64'(9));
    iv = '0;

    // Backpressure on E with six flits queued from L
    do_reset();
    for (int i = 0; i < 6; i++) begin
      r = $urandom();
      flits[i] = mk(3, 1 + (i % 3), r);
      flits[i][35:34] = 2'd3;
    end
    k = 0; bad = 0;
    for (int c = 0; c < 10; c++) begin
      cyc();
      ordy = 5'b11011;
      iv = {4'b0, k < 6};
      ifl[0 +: FW] = (k < 6) ? flits[k] : '0;
      #1;
      if (ov[2] && (ofl[2*FW +: FW] !== flits[0])) bad++;
      if (iv[0] && ir[0]) k++;
    end
    check_eq("bp_accepts", 64'(k), 64'(4));
    check_eq("bp_ready_low", 64'(ir[0]), 64'(0));
    check_eq("bp_stable", 64'(bad), 64'(0));
    got = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      cyc();
      ordy = 5'h1F;
      iv = {4'b0, k < 6};
      ifl[0 +: FW] = (k < 6) ? flits[k] : '0;
      #1;
      if (ov[2]) begin
        check_eq("bp_order", 64'(ofl[2*FW +: FW]), 64'(flits[got]));
        got++;
      end
      if (iv[0] && ir[0]) k++;
    end
    check_eq("bp_delivered", 64'(got), 64'(6));
    iv = '0;

    // Corner router: U-turn on E input is dropped
    do_reset();
    cyc();
    e_iv = 5'b00100; e_ifl[2*FW +: FW] = mk(3, 0, 32'hA5A5_0002);
    cyc();
    e_iv = '0;
    #1 check_eq("edge_uturn_noout", 64'(e_ov), 64'(0));
    cyc();
    check_eq("edge_drop", 64'(e_drop), 64'(1));
    check_eq("edge_absent_flit", 64'({e_ofl[1*FW +: FW], e_ofl[4*FW +: FW]}), 64'(0));
    check_eq("edge_absent_ready", 64'({e_ir[4], e_ir[1]}), 64'(0));

    // Mid-operation reset discards buffered flits
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc();
      iv = 5'b00001; ifl[0 +: FW] = mk(3, 1, 32'(i));
    end
    cyc();
    iv = '0;
    #1 check_eq("midrst_buffered", 64'(ov[2]), 64'(1));
    rst = 1'b0;
    #1 check_eq("midrst_async", 64'(ov), 64'(0));
    cyc();
    rst = 1'b1;
    ordy = 5'h1F;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      cyc();
      #1 if (ov != 0) bad++;
    end
    check_eq("midrst_nothing", 64'(bad), 64'(0));

    // Randomised traffic against per-(input,output) order queues
    do_reset();
    exp_drop = 0;
    for (int c = 0; c < 460; c++) begin
      cyc();
      if (c < 400) begin
        iv = 5'($urandom());
        for (int p = 0; p < 5; p++) begin
          r = $urandom(); r[2:0] = 3'(p);
          ifl[p*FW +: FW] = mk($urandom_range(0, 3), $urandom_range(0, 3), r);
        end
        for (int o = 0; o < 5; o++) ordy[o] = ($urandom_range(0, 3) != 0);
      end else begin
        iv = '0; ordy = 5'h1F;
      end
      #1;
      for (int o = 0; o < 5; o++) begin
        if (ov[o] && ordy[o]) begin
          f = ofl[o*FW +: FW];
          s = int'(f[2:0]);
          if (s < 5 && mq[s*5+o].size() > 0) ef = mq[s*5+o].pop_front();
          else ef = ~f;
          check_eq("rand_flit", 64'(f), 64'(ef));
        end
      end
      for (int p = 0; p < 5; p++) begin
        if (iv[p] && ir[p]) begin
          f = ifl[p*FW +: FW];
          rp = exp_port(int'(f[35:34]), int'(f[33:32]));
          if (rp == p && p != 0) exp_drop++;
          else mq[p*5+rp].push_back(f);
        end
      end
    end
    left = 0;
    for (int i = 0; i < 25; i++) left += mq[i].size();
    check_eq("rand_drained", 64'(left), 64'(0));
    check_eq("rand_drops", 64'(drop), 64'(exp_drop));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
